// File: rtl/clg_seq_adder_if.sv
// ---------------------------------------------------------------------------
// clg_seq_adder_if
// Request/result bundle for the nibble-serial lookahead adder.
//   start   : request, sampled by the adder only while it is idle
//   a, b    : WIDTH-bit operands, sampled with start
//   cin     : carry-in, sampled with start
//   busy    : addition in progress
//   done    : one-cycle pulse, sum/cout/ovf valid
//   sum     : (a + b + cin) mod 2^WIDTH
//   cout    : carry out of bit WIDTH-1
//   ovf     : signed overflow
// Modports: master drives the request side, slave is the adder.
// ---------------------------------------------------------------------------
interface clg_seq_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/clg_seq_adder.sv
// ---------------------------------------------------------------------------
// clg_seq_adder
// Iterative WIDTH-bit adder resolving one 4-bit nibble per clock with a
// two-level carry-lookahead equation; the nibble carry-out is chained through
// a carry register. Intended as the small adder inside multi-cycle loops.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : clg_seq_adder_if.slave (start/a/b/cin in, busy/done/sum/cout/ovf out)
// Latency: start accepted at edge k, nibbles at edges k+1..k+N, done high in
// the cycle after edge k+N (N = WIDTH/4).
// ---------------------------------------------------------------------------
module clg_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  clg_seq_adder_if.slave    bus
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;

  // Current nibble lookahead
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic [3:0] s;

  // NOTE: every signal in this block is assigned on every path, so no latch
  // is inferred; any conditional assignment added later needs a default first.
  always_comb begin
    a_nib = a_q[4*idx +: 4];
    b_nib = b_q[4*idx +: 4];
    g     = a_nib & b_nib;
    p     = a_nib ^ b_nib;
    // Carries flattened to sum-of-products so the nibble resolves in two
    // gate levels rather than rippling through four.
    c[0]  = g[0]
          | (p[0] & carry_q);
    c[1]  = g[1]
          | (p[1] & g[0])
          | (p[1] & p[0] & carry_q);
    c[2]  = g[2]
          | (p[2] & g[1])
          | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & carry_q);
    c[3]  = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s     = p ^ {c[2:0], carry_q};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // The operand registers are plain flops, not a memory, so clearing
      // them costs nothing and keeps the datapath free of X after reset.
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Partial sum is visible during BUSY; only valid when done=1.
          sum_q[4*idx +: 4] <= s;
          carry_q           <= c[3];
          if (idx == LAST_IDX) begin
            // Carry into the MSB is c[2] of the top nibble.
            cout_q <= c[3];
            ovf_q  <= c[2] ^ c[3];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            idx    <= '0;
            state  <= IDLE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
